mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_pkg.sv | 19 +
 rtl/mux_arbiter_mux2_reg.sv | 38 +++
 rtl/mux_arbiter.sv | 116 +++++++++++
 tb/tb_mux_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-source capture arbiter.
//   NBITS_DEF : default data width
//   BURST_DEF : default run limit for one source under contention
//   RUN_W     : width of the consecutive-grant run counter
//   state_e   : output register occupancy (IDLE = empty, FULL = holds a word)
package mux_arbiter_pkg;

  localparam int unsigned NBITS_DEF = 8;
  localparam int unsigned BURST_DEF = 4;
  localparam int unsigned RUN_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  typedef logic [RUN_W-1:0] run_t;

endpackage

// File: rtl/mux_arbiter_mux2_reg.sv
// NBITS-wide 2:1 mux feeding a load-enabled output register.
//   clk, rst : clock, asynchronous active-high reset (register clears to 0)
//   load_i   : capture the selected input on this edge
//   sel_i    : 0 selects a_i, 1 selects b_i
//   a_i, b_i : candidate words
//   q_o      : registered word
module mux2_reg #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             sel_i,
  input  logic [NBITS-1:0] a_i,
  input  logic [NBITS-1:0] b_i,
  output logic [NBITS-1:0] q_o
);

  logic [NBITS-1:0] mux_c;
  logic [NBITS-1:0] q_q;

  // Source select.
  always_comb begin
    mux_c = sel_i ? b_i : a_i;
  end

  // Output register; holds whenever no load is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= mux_c;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mux_arbiter.sv
// Two-source arbiter with a single-entry registered output.
//   clk, rst       : clock, asynchronous active-high reset
//   req0/di0       : source 0 request and data
//   req1/di1       : source 1 request and data
//   gnt0/gnt1      : combinational one-cycle grant, word captured on this edge
//   do_valid       : output register holds an unconsumed word
//   do_data/do_src : registered word and the source it came from
//   do_ready       : consumer accepts do_data while do_valid is high
// Contention is resolved by a priority pointer that follows the last winner,
// with a run counter forcing a hand-over after BURST consecutive grants.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned BURST = BURST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [NBITS-1:0] di0,
  input  logic             req1,
  input  logic [NBITS-1:0] di1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             do_valid,
  output logic [NBITS-1:0] do_data,
  output logic             do_src,
  input  logic             do_ready
);

  localparam run_t BURST_RUN = RUN_W'(BURST);

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;
  run_t   run_q, run_d;
  logic   src_q, src_d;

  logic   open_c;
  logic   any_req_c;
  logic   limit_c;
  logic   winner_c;
  logic   grant_c;

  // Capture slot, winner selection and next-state decode.
  always_comb begin
    open_c    = (state_q == IDLE) || do_ready;
    any_req_c = req0 || req1;
    limit_c   = (run_q == BURST_RUN);
    // Grants are suppressed while reset is held so nothing is pulsed then.
    grant_c   = open_c && any_req_c && !rst;

    winner_c = 1'b0;
    if (req0 && req1) begin
      winner_c = limit_c ? ~ptr_q : ptr_q;
    end else if (req1) begin
      winner_c = 1'b1;
    end

    state_d = state_q;
    ptr_d   = ptr_q;
    run_d   = run_q;
    src_d   = src_q;

    if (grant_c) begin
      state_d = FULL;
      ptr_d   = winner_c;
      src_d   = winner_c;
      // ptr always tracks the previous winner, so it decides run restart.
      if (winner_c != ptr_q) begin
        run_d = RUN_W'(1);
      end else if (!limit_c) begin
        run_d = run_q + RUN_W'(1);
      end
    end else begin
      if (open_c && !any_req_c) begin
        run_d = '0;
      end
      if ((state_q == FULL) && do_ready) begin
        state_d = IDLE;
      end
    end
  end

  // State, pointer, run counter and source tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      run_q   <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      run_q   <= run_d;
      src_q   <= src_d;
    end
  end

  mux2_reg #(
    .NBITS (NBITS)
  ) u_mux2_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (grant_c),
    .sel_i  (winner_c),
    .a_i    (di0),
    .b_i    (di1),
    .q_o    (do_data)
  );

  assign gnt0     = grant_c && !winner_c;
  assign gnt1     = grant_c && winner_c;
  assign do_valid = (state_q == FULL);
  assign do_src   = src_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed and randomized checks of mux_arbiter with NBITS=8, BURST=4.
module tb_mux_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic [7:0] di0;
  logic       req1;
  logic [7:0] di1;
  logic       gnt0;
  logic       gnt1;
  logic       do_valid;
  logic [7:0] do_data;
  logic       do_src;
  logic       do_ready;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(
    .NBITS (8),
    .BURST (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .di0      (di0),
    .req1     (req1),
    .di1      (di1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .do_valid (do_valid),
    .do_data  (do_data),
    .do_src   (do_src),
    .do_ready (do_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; di0 = 8'h00; di1 = 8'h00; do_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Requests are high throughout reset; nothing may be granted or captured.
    repeat (2) @(negedge clk);
    checks++; if (do_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", do_valid); end
    checks++; if (do_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", do_data); end
    checks++; if (do_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %0h expected 0", do_src); end
    checks++; if ({gnt1, gnt0} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %0b expected 00", {gnt1, gnt0}); end
    do_reset();
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b00) begin errors++; $display("FAIL reset_idle_gnt: got %0b expected 00", {gnt1, gnt0}); end
  endtask

  task automatic test_single();
    @(negedge clk);
    req0 = 1'b1; di0 = 8'h01; do_ready = 1'b1;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL single_gnt: got %0b expected 01", {gnt1, gnt0}); end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    checks++; if ({do_valid, do_src, do_data} !== {1'b1, 1'b0, 8'h01}) begin
      errors++; $display("FAIL single_out: got v=%0h s=%0h d=%0h expected v=1 s=0 d=01", do_valid, do_src, do_data);
    end
    @(negedge clk);
    checks++; if (do_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0h expected 0", do_valid); end
  endtask

  task automatic test_burst();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; di0 = 8'h01; di1 = 8'h0F; do_ready = 1'b1;
      #1;
      exp_g = (((i / 4) % 2) == 1) ? 2'b10 : 2'b01;
      checks++; if ({gnt1, gnt0} !== exp_g) begin
        errors++; $display("FAIL burst_gnt[%0d]: got %0b expected %0b", i, {gnt1, gnt0}, exp_g);
      end
      if (i > 0) begin
        exp_d = ((((i - 1) / 4) % 2) == 1) ? 8'h0F : 8'h01;
        checks++; if ({do_valid, do_data} !== {1'b1, exp_d}) begin
          errors++; $display("FAIL burst_data[%0d]: got v=%0h d=%0h expected v=1 d=%0h", i, do_valid, do_data, exp_d);
        end
      end
    end
  endtask

  task automatic test_stall();
    // Source 0 has just finished a run of 4, so source 1 must win on release.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      do_ready = 1'b0;
      #1;
      checks++; if ({gnt1, gnt0, do_valid, do_data} !== {2'b00, 1'b1, 8'h01}) begin
        errors++; $display("FAIL stall[%0d]: got g=%0b v=%0h d=%0h expected g=00 v=1 d=01", i, {gnt1, gnt0}, do_valid, do_data);
      end
    end
    @(negedge clk);
    do_ready = 1'b1;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL stall_release_gnt: got %0b expected 10", {gnt1, gnt0}); end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    checks++; if ({do_valid, do_src, do_data} !== {1'b1, 1'b1, 8'h0F}) begin
      errors++; $display("FAIL stall_b2b: got v=%0h s=%0h d=%0h expected v=1 s=1 d=0f", do_valid, do_src, do_data);
    end
    @(negedge clk);
    checks++; if (do_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %0h expected 0", do_valid); end
  endtask

  task automatic test_req1_only();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b1; di1 = 8'(16 + i); do_ready = 1'b1;
      #1;
      checks++; if ({gnt1, gnt0} !== 2'b10) begin
        errors++; $display("FAIL req1_gnt[%0d]: got %0b expected 10", i, {gnt1, gnt0});
      end
      if (i > 0) begin
        checks++; if ({do_src, do_data} !== {1'b1, 8'(16 + i - 1)}) begin
          errors++; $display("FAIL req1_data[%0d]: got s=%0h d=%0h expected s=1 d=%0h", i, do_src, do_data, 8'(16 + i - 1));
        end
      end
    end
    // Source 1's run is saturated at the limit, so contention goes to source 0.
    @(negedge clk);
    req0 = 1'b1; di0 = 8'h33; req1 = 1'b1; di1 = 8'h44;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL req1_handover: got %0b expected 01", {gnt1, gnt0}); end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    checks++; if ({do_src, do_data} !== {1'b0, 8'h33}) begin
      errors++; $display("FAIL req1_handover_data: got s=%0h d=%0h expected s=0 d=33", do_src, do_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req1 = 1'b1; di1 = 8'hA5; do_ready = 1'b1;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL rmid_gnt: got %0b expected 10", {gnt1, gnt0}); end
    @(negedge clk);
    do_ready = 1'b0; di1 = 8'h5A;
    #1;
    checks++; if ({gnt1, gnt0, do_valid, do_data} !== {2'b00, 1'b1, 8'hA5}) begin
      errors++; $display("FAIL rmid_hold: got g=%0b v=%0h d=%0h expected g=00 v=1 d=a5", {gnt1, gnt0}, do_valid, do_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if ({gnt1, gnt0, do_valid, do_src, do_data} !== {2'b00, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rmid_async: got g=%0b v=%0h s=%0h d=%0h expected all 0", {gnt1, gnt0}, do_valid, do_src, do_data);
    end
    @(negedge clk);
    checks++; if ({gnt1, gnt0, do_valid} !== 3'b000) begin
      errors++; $display("FAIL rmid_held: got g=%0b v=%0h expected g=00 v=0", {gnt1, gnt0}, do_valid);
    end
    rst = 1'b0;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL rmid_first_gnt: got %0b expected 10", {gnt1, gnt0}); end
    @(negedge clk);
    req1 = 1'b0; do_ready = 1'b1;
    #1;
    checks++; if ({do_valid, do_src, do_data} !== {1'b1, 1'b1, 8'h5A}) begin
      errors++; $display("FAIL rmid_reload: got v=%0h s=%0h d=%0h expected v=1 s=1 d=5a", do_valid, do_src, do_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [8:0] head;
    logic       got0;
    logic       got1;
    int         delivered;
    got0 = 1'b0; got1 = 1'b0; delivered = 0;
    req0 = 1'b0; req1 = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (got0) req0 = 1'b0;
      if (got1) req1 = 1'b0;
      checks++; if (exp_q.size() != int'(do_valid)) begin
        errors++; $display("FAIL rand_occupancy[%0d]: got v=%0h expected queued=%0d", cyc, do_valid, exp_q.size());
      end
      do_ready = ($urandom_range(0, 3) != 0);
      if (do_valid && do_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_dup[%0d]: got word %0h expected none", cyc, do_data);
        end else begin
          head = exp_q.pop_front();
          delivered++;
          if ({do_src, do_data} !== head) begin
            errors++; $display("FAIL rand_word[%0d]: got %0h expected %0h", cyc, {do_src, do_data}, head);
          end
        end
      end
      if (!req0) begin
        if ($urandom_range(0, 1) == 1) begin req0 = 1'b1; di0 = 8'($urandom); end
      end else if ($urandom_range(0, 15) == 0) begin
        req0 = 1'b0;
      end
      if (!req1) begin
        if ($urandom_range(0, 1) == 1) begin req1 = 1'b1; di1 = 8'($urandom); end
      end else if ($urandom_range(0, 15) == 0) begin
        req1 = 1'b0;
      end
      #1;
      checks++;
      if ((gnt0 && gnt1) || (gnt0 && !req0) || (gnt1 && !req1) ||
          ((gnt0 || gnt1) && do_valid && !do_ready) ||
          (!(gnt0 || gnt1) && (req0 || req1) && !(do_valid && !do_ready))) begin
        errors++; $display("FAIL rand_gnt[%0d]: got g=%0b expected legal grant (r=%0b v=%0h rdy=%0h)",
                           cyc, {gnt1, gnt0}, {req1, req0}, do_valid, do_ready);
      end
      got0 = gnt0;
      got1 = gnt1;
      if (gnt0) exp_q.push_back({1'b0, di0});
      if (gnt1) exp_q.push_back({1'b1, di1});
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; do_ready = 1'b1;
    if (do_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL rand_tail_dup: got word %0h expected none", do_data);
      end else begin
        head = exp_q.pop_front();
        delivered++;
        if ({do_src, do_data} !== head) begin
          errors++; $display("FAIL rand_tail_word: got %0h expected %0h", {do_src, do_data}, head);
        end
      end
    end
    @(negedge clk);
    checks++; if ((do_valid !== 1'b0) || (exp_q.size() != 0)) begin
      errors++; $display("FAIL rand_drain: got v=%0h queued=%0d expected v=0 queued=0", do_valid, exp_q.size());
    end
    checks++; if (delivered < 1000) begin
      errors++; $display("FAIL rand_delivered: got %0d expected at least 1000", delivered);
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; di0 = 8'hAA; di1 = 8'h55; do_ready = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_stall();
    test_req1_only();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
